// File: rtl/des_block_loader_if.sv
// Bus bundles for the DES block loader: the 32-bit input word stream and
// the write side of DPRAM port 0.

interface des_stream_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

interface des_mem_if #(
  parameter int AW = 6,
  parameter int DW = 64
);
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_data;

  modport master (output mem_en, output mem_wr, output mem_add, output mem_data);
  modport slave  (input  mem_en, input  mem_wr, input  mem_add, input  mem_data);
endinterface

// File: rtl/des_block_loader.sv
// Packs 32-bit stream word pairs into 64-bit DES blocks and writes them to DPRAM port 0.
// Optional running XOR checksum of written blocks: define DES_LOADER_XOR_CHK_EN.

module des_block_loader #(
  parameter int          AW        = 6,
  parameter int          DW        = 64,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW:0]   i_blk_count,
  input  logic          i_abort,
  des_stream_if.slave   s_if,
  des_mem_if.master     m_if,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
`ifdef DES_LOADER_XOR_CHK_EN
  ,
  output logic [DW-1:0] o_chk_out
`endif
);

  localparam logic [AW:0]   MAX_BLK = (AW+1)'(2**AW);
  localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_FIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_hi;
  logic [AW:0]   r_rem;
  logic [AW-1:0] r_addr;
  logic          w_hs;
  logic          w_start_req;
  logic          w_start_ok;
  logic          w_start_bad;

  assign w_start_req = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_start_ok  = w_start_req && (i_blk_count <= MAX_BLK);
  assign w_start_bad = w_start_req && (i_blk_count >  MAX_BLK);

  // Abort drops ready in the same cycle so no word is consumed while cancelling.
  assign s_if.s_ready = ((r_state == ST_HI) || (r_state == ST_LO)) && !i_abort;
  assign w_hs         = s_if.s_valid && s_if.s_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use non-blocking <= so every register samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = (i_blk_count == '0) ? ST_FIN : ST_HI;
      end
      ST_HI: begin
        if (i_abort)   w_state_nxt = ST_IDLE;
        else if (w_hs) w_state_nxt = ST_LO;
      end
      ST_LO: begin
        if (i_abort)   w_state_nxt = ST_IDLE;
        else if (w_hs) w_state_nxt = (r_rem == (AW+1)'(1)) ? ST_FIN : ST_HI;
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi          <= '0;
      r_rem         <= '0;
      r_addr        <= BASE;
      m_if.mem_en   <= 1'b0;
      m_if.mem_wr   <= 1'b0;
      m_if.mem_add  <= BASE;
      m_if.mem_data <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      m_if.mem_en <= 1'b0;
      m_if.mem_wr <= 1'b0;
      o_busy      <= (w_state_nxt == ST_HI) || (w_state_nxt == ST_LO);
      o_done      <= (r_state == ST_FIN);
      o_err       <= w_start_bad;

      if (w_start_ok) begin
        r_rem  <= i_blk_count;
        r_addr <= BASE;
      end

      if ((r_state == ST_HI) && w_hs) r_hi <= s_if.s_data;

      // Second word of a pair: strobe the block out next cycle; address wraps mod 2**AW.
      if ((r_state == ST_LO) && w_hs) begin
        m_if.mem_en   <= 1'b1;
        m_if.mem_wr   <= 1'b1;
        m_if.mem_add  <= r_addr;
        m_if.mem_data <= DW'({r_hi, s_if.s_data});
        r_addr        <= r_addr + AW'(1);
        r_rem         <= r_rem - (AW+1)'(1);
      end
    end
  end

`ifdef DES_LOADER_XOR_CHK_EN
  logic [DW-1:0] r_chk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_chk <= '0;
    else if (w_start_ok)                r_chk <= '0;
    else if (m_if.mem_en && m_if.mem_wr) r_chk <= r_chk ^ m_if.mem_data;
  end

  assign o_chk_out = r_chk;
`endif

endmodule
